// File: rtl/lpc_pkg.sv
// -----------------------------------------------------------------------------
// lpc_pkg
// Shared LPC definitions for the host-side initiator and the LPC sniffer:
// FSM state encoding, cycle-type and SYNC nibble codes, completion status
// codes, default timing limits and the address nibble serializer.
// -----------------------------------------------------------------------------
package lpc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_CYCTYPE,
    ST_ADDR,
    ST_WDATA,
    ST_TAR_H,
    ST_SYNC,
    ST_RDATA,
    ST_TAR_P,
    ST_ABORT,
    ST_RESP
  } lpc_state_e;

  // Cycle type / direction nibble driven after START.
  localparam logic [3:0] CYC_IO_READ  = 4'b0000;
  localparam logic [3:0] CYC_IO_WRITE = 4'b0010;

  // Peripheral SYNC codes.
  localparam logic [3:0] SYNC_READY      = 4'b0000;
  localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
  localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
  localparam logic [3:0] SYNC_ERROR      = 4'b1010;
  localparam logic [3:0] SYNC_NONE       = 4'b1111;

  typedef enum logic [1:0] {
    STAT_OK         = 2'd0,
    STAT_TIMEOUT    = 2'd1,
    STAT_SYNC_ERR   = 2'd2,
    STAT_WAIT_LIMIT = 2'd3
  } lpc_status_e;

  localparam int DEF_SYNC_TIMEOUT = 3;
  localparam int DEF_WAIT_LIMIT   = 255;

  // Address nibbles go out MSB first: idx 0 -> addr[15:12].
  function automatic logic [3:0] addr_nibble(input logic [15:0] addr,
                                             input logic [1:0]  idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = addr[15:12];
      2'd1:    nib = addr[11:8];
      2'd2:    nib = addr[7:4];
      default: nib = addr[3:0];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/lpc_host_io_if.sv
// -----------------------------------------------------------------------------
// lpc_host_io_if
// Bundles the request/response handshake and the LPC pin-side signals of the
// host initiator.
//   slave  : the lpc_host_io block (accepts requests, drives LFRAME#/LAD).
//   master : the requester / bus environment.
// Signals: req_valid/req_ready/req_write/req_addr/req_wdata (request),
//          resp_valid/resp_rdata/resp_status (completion),
//          lpc_frame/lpc_ad_out/lpc_ad_oe (host drive), lpc_ad_in (sampled LAD).
// -----------------------------------------------------------------------------
interface lpc_host_io_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic [1:0]  resp_status;
  logic        lpc_frame;
  logic [3:0]  lpc_ad_out;
  logic        lpc_ad_oe;
  logic [3:0]  lpc_ad_in;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, lpc_ad_in,
    output req_ready, resp_valid, resp_rdata, resp_status,
           lpc_frame, lpc_ad_out, lpc_ad_oe
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, lpc_ad_in,
    input  req_ready, resp_valid, resp_rdata, resp_status,
           lpc_frame, lpc_ad_out, lpc_ad_oe
  );
endinterface

// File: rtl/lpc_host_io.sv
// -----------------------------------------------------------------------------
// lpc_host_io
// LPC host initiator: runs one I/O read or I/O write cycle per accepted
// request and reports a one-cycle completion with status and read data.
// Ports:
//   lpc_clock : LCLK, all logic on the rising edge.
//   lpc_reset : asynchronous active-low reset.
//   bus       : lpc_host_io_if.slave (request, response and LAD/LFRAME# pins).
// All pin and response outputs are registered; each is decoded from the
// next state so it lines up with the state it belongs to.
// -----------------------------------------------------------------------------
module lpc_host_io
  import lpc_pkg::*;
#(
  parameter int SYNC_TIMEOUT = DEF_SYNC_TIMEOUT,
  parameter int WAIT_LIMIT   = DEF_WAIT_LIMIT
) (
  input  logic          lpc_clock,
  input  logic          lpc_reset,
  lpc_host_io_if.slave  bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(SYNC_TIMEOUT);
  localparam logic [7:0] WAIT_CNT    = 8'(WAIT_LIMIT);

  lpc_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;           // phase counter inside multi-clock states
  logic [7:0]  wait_cnt_q, wait_cnt_d; // consecutive wait SYNCs
  logic [7:0]  nr_cnt_q, nr_cnt_d;     // consecutive 1111 SYNCs
  lpc_status_e status_q, status_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        write_q, write_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;

  logic        frame_q, frame_d;
  logic        oe_q, oe_d;
  logic [3:0]  ad_q, ad_d;
  logic        ready_q, ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [7:0]  resp_rdata_q, resp_rdata_d;
  logic [1:0]  resp_status_q, resp_status_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_cnt_d = wait_cnt_q;
    nr_cnt_d   = nr_cnt_q;
    status_d   = status_q;
    rdata_d    = rdata_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && ready_q) begin
          write_d    = bus.req_write;
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          status_d   = STAT_OK;
          rdata_d    = 8'h00;
          wait_cnt_d = 8'h00;
          nr_cnt_d   = 8'h00;
          cnt_d      = 3'd0;
          state_d    = ST_START;
        end
      end
      ST_START:   state_d = ST_CYCTYPE;
      ST_CYCTYPE: begin
        cnt_d   = 3'd0;
        state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (cnt_q == 3'd3) begin
          cnt_d   = 3'd0;
          state_d = write_q ? ST_WDATA : ST_TAR_H;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_WDATA: begin
        if (cnt_q == 3'd1) begin
          cnt_d   = 3'd0;
          state_d = ST_TAR_H;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_TAR_H: begin
        if (cnt_q == 3'd1) begin
          cnt_d   = 3'd0;
          state_d = ST_SYNC;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_SYNC: begin
        // Each counter only tracks an unbroken run of its own code.
        wait_cnt_d = 8'h00;
        nr_cnt_d   = 8'h00;
        cnt_d      = 3'd0;
        if (bus.lpc_ad_in == SYNC_READY || bus.lpc_ad_in == SYNC_ERROR) begin
          // An error SYNC still runs the normal data/turnaround phases.
          if (bus.lpc_ad_in == SYNC_ERROR) status_d = STAT_SYNC_ERR;
          state_d = write_q ? ST_TAR_P : ST_RDATA;
        end else if (bus.lpc_ad_in == SYNC_SHORT_WAIT ||
                     bus.lpc_ad_in == SYNC_LONG_WAIT) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_d == WAIT_CNT) begin
            status_d = STAT_WAIT_LIMIT;
            state_d  = ST_ABORT;
          end
        end else if (bus.lpc_ad_in == SYNC_NONE) begin
          nr_cnt_d = nr_cnt_q + 8'd1;
          if (nr_cnt_d == TIMEOUT_CNT) begin
            status_d = STAT_TIMEOUT;
            state_d  = ST_ABORT;
          end
        end else begin
          status_d = STAT_SYNC_ERR;
          state_d  = ST_ABORT;
        end
      end
      ST_RDATA: begin
        if (cnt_q == 3'd0) begin
          rdata_d[3:0] = bus.lpc_ad_in;
          cnt_d        = 3'd1;
        end else begin
          rdata_d[7:4] = bus.lpc_ad_in;
          cnt_d        = 3'd0;
          state_d      = ST_TAR_P;
        end
      end
      ST_TAR_P: begin
        if (cnt_q == 3'd1) begin
          cnt_d   = 3'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_ABORT: begin
        // Clocks 0..3 hold LFRAME# low, clock 4 releases it.
        if (cnt_q == 3'd4) begin
          cnt_d   = 3'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Output decode from the next state, registered below.
    frame_d       = 1'b1;
    oe_d          = 1'b0;
    ad_d          = SYNC_NONE;
    ready_d       = 1'b0;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = 8'h00;
    resp_status_d = 2'd0;
    unique case (state_d)
      ST_IDLE:    ready_d = 1'b1;
      ST_START: begin
        frame_d = 1'b0;
        oe_d    = 1'b1;
        ad_d    = 4'b0000;
      end
      ST_CYCTYPE: begin
        oe_d = 1'b1;
        ad_d = write_d ? CYC_IO_WRITE : CYC_IO_READ;
      end
      ST_ADDR: begin
        oe_d = 1'b1;
        ad_d = addr_nibble(addr_d, cnt_d[1:0]);
      end
      ST_WDATA: begin
        oe_d = 1'b1;
        ad_d = cnt_d[0] ? wdata_d[7:4] : wdata_d[3:0];
      end
      // Drive 1111 for one clock, then release LAD to the peripheral.
      ST_TAR_H:   oe_d = (cnt_d == 3'd0);
      ST_ABORT: begin
        oe_d    = 1'b1;
        frame_d = (cnt_d == 3'd4);
      end
      ST_RESP: begin
        resp_valid_d  = 1'b1;
        resp_status_d = status_d;
        resp_rdata_d  = (status_d == STAT_OK && !write_d) ? rdata_d : 8'h00;
      end
      default: ;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 3'd0;
      wait_cnt_q    <= 8'h00;
      nr_cnt_q      <= 8'h00;
      status_q      <= STAT_OK;
      rdata_q       <= 8'h00;
      write_q       <= 1'b0;
      addr_q        <= 16'h0000;
      wdata_q       <= 8'h00;
      frame_q       <= 1'b1;
      oe_q          <= 1'b0;
      ad_q          <= SYNC_NONE;
      ready_q       <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 8'h00;
      resp_status_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      nr_cnt_q      <= nr_cnt_d;
      status_q      <= status_d;
      rdata_q       <= rdata_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      frame_q       <= frame_d;
      oe_q          <= oe_d;
      ad_q          <= ad_d;
      ready_q       <= ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_status_q <= resp_status_d;
    end
  end

  assign bus.lpc_frame   = frame_q;
  assign bus.lpc_ad_oe   = oe_q;
  assign bus.lpc_ad_out  = ad_q;
  assign bus.req_ready   = ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_status = resp_status_q;

endmodule
